// File: rtl/hawk_rd_arb.sv
// ----------------------------------------------------------------------------
// hawk_rd_arb: two-requester AXI4 read arbiter, one outstanding burst.
// Option: HAWK_RD_ARB_STRICT_PRIO_EN (requester 0 always wins). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hawk_rd_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        req_valid_i,
  input  logic [ADDR_W-1:0] req_addr0_i,
  input  logic [ADDR_W-1:0] req_addr1_i,
  input  logic [7:0]        req_len0_i,
  input  logic [7:0]        req_len1_i,
  output logic [1:0]        req_ready_o,
  output logic [1:0]        rsp_valid_o,
  input  logic [1:0]        rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [1:0]        rsp_resp_o,
  output logic              rsp_last_o,
  output logic [ADDR_W-1:0] m_araddr_o,
  output logic [7:0]        m_arlen_o,
  output logic [ID_W-1:0]   m_arid_o,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  input  logic              m_rvalid_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  input  logic [1:0]        m_rresp_i,
  input  logic              m_rlast_i,
  input  logic [ID_W-1:0]   m_rid_i,
  output logic              m_rready_o,
  output logic              len_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              err_q, err_d;
  logic              win;
  logic [1:0]        win_oh;
  logic              beat;

`ifdef HAWK_RD_ARB_STRICT_PRIO_EN
  assign win = ~req_valid_i[0];
`else
  logic ptr_q, ptr_d;

  // A lone requester wins; the pointer only breaks ties.
  assign win = (&req_valid_i) ? ptr_q : ~req_valid_i[0];

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && (|req_valid_i)) ptr_d = ~win;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end
`endif

  assign win_oh = win ? 2'b10 : 2'b01;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    req_ready_o = 2'b00;
    rsp_valid_o = 2'b00;
    rsp_data_o  = '0;
    rsp_resp_o  = 2'b00;
    rsp_last_o  = 1'b0;
    m_rready_o  = 1'b0;
    beat        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          req_ready_o = win_oh;
          addr_d      = win ? req_addr1_i : req_addr0_i;
          len_d       = win ? req_len1_i : req_len0_i;
          cnt_d       = win ? req_len1_i : req_len0_i;
          owner_d     = win;
          state_d     = ST_AR;
        end
      end
      ST_AR: begin
        if (m_arready_i) state_d = ST_R;
      end
      ST_R: begin
        rsp_valid_o = owner_q ? {m_rvalid_i, 1'b0} : {1'b0, m_rvalid_i};
        m_rready_o  = rsp_ready_i[owner_q];
        rsp_data_o  = m_rdata_i;
        rsp_resp_o  = m_rresp_i;
        rsp_last_o  = m_rlast_i;
        beat        = m_rvalid_i & rsp_ready_i[owner_q];
        if (beat) begin
          // Early/late rlast and foreign IDs all fold into the one sticky flag.
          if ((m_rlast_i && cnt_q != 8'd0) || (!m_rlast_i && cnt_q == 8'd0) ||
              (m_rid_i != ID_W'(owner_q)))
            err_d = 1'b1;
          if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
          if (m_rlast_i) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  assign m_arvalid_o = (state_q == ST_AR);
  assign m_araddr_o  = addr_q;
  assign m_arlen_o   = len_q;
  assign m_arid_o    = ID_W'(owner_q);
  assign len_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_hawk_rd_arb.sv
// ----------------------------------------------------------------------------
// tb_hawk_rd_arb: directed scoreboard bench for hawk_rd_arb. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hawk_rd_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [63:0]  req_addr0, req_addr1;
  logic [7:0]   req_len0, req_len1;
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [511:0] rsp_data;
  logic [1:0]   rsp_resp;
  logic         rsp_last;
  logic [63:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic [3:0]   m_arid;
  logic         m_arvalid, m_arready;
  logic         m_rvalid;
  logic [511:0] m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rlast;
  logic [3:0]   m_rid;
  logic         m_rready;
  logic         len_err;

  typedef struct {
    bit           owner;
    logic [511:0] data;
    logic [1:0]   resp;
    bit           last;
  } beat_t;

  beat_t bq[$];
  bit    gq[$];
  int    total = 0;
  int    bad   = 0;

  hawk_rd_arb dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_addr0_i(req_addr0), .req_addr1_i(req_addr1),
    .req_len0_i(req_len0), .req_len1_i(req_len1), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_resp_o(rsp_resp), .rsp_last_o(rsp_last),
    .m_araddr_o(m_araddr), .m_arlen_o(m_arlen), .m_arid_o(m_arid),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
    .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
    .m_rlast_i(m_rlast), .m_rid_i(m_rid), .m_rready_o(m_rready),
    .len_err_o(len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".req_ready"}, req_ready, 0);
    chk({tag, ".rsp_valid"}, rsp_valid, 0);
    chk({tag, ".rsp_data"},  rsp_data, 0);
    chk({tag, ".rsp_last"},  rsp_last, 0);
    chk({tag, ".arvalid"},   m_arvalid, 0);
    chk({tag, ".araddr"},    m_araddr, 0);
    chk({tag, ".arlen"},     m_arlen, 0);
    chk({tag, ".arid"},      m_arid, 0);
    chk({tag, ".rready"},    m_rready, 0);
    chk({tag, ".len_err"},   len_err, 0);
  endtask

  // Drives req_valid for one cycle and checks the same-cycle grant.
  task automatic request(input logic [1:0] v, input bit w);
    bit ew;
    gq.push_back(w);
    req_valid = v;
    @(negedge clk);
    ew = gq.pop_front();
    chk("grant", req_ready, ew ? 2'b10 : 2'b01);
    @(posedge clk); #1;
  endtask

  task automatic ar_phase(input logic [63:0] a, input logic [7:0] l, input logic [3:0] id,
                          input int waits);
    for (int i = 0; i <= waits; i++) begin
      m_arready = (i == waits);
      @(negedge clk);
      chk("arvalid", m_arvalid, 1);
      chk("araddr", m_araddr, a);
      chk("arlen", m_arlen, l);
      chk("arid", m_arid, id);
      chk("nonowner_ready", req_ready, 0);
      chk("ar_rready", m_rready, 0);
      @(posedge clk); #1;
    end
    m_arready = 1'b0;
  endtask

  // One R beat; during stall cycles only the non-owner is ready.
  task automatic beat(input bit o, input logic [511:0] d, input logic [1:0] rr, input bit last,
                      input logic [3:0] rid, input int stalls);
    logic [1:0] oh;
    beat_t      e;
    oh = o ? 2'b10 : 2'b01;
    bq.push_back('{owner: o, data: d, resp: rr, last: last});
    m_rvalid = 1'b1; m_rdata = d; m_rresp = rr; m_rlast = last; m_rid = rid;
    for (int i = 0; i <= stalls; i++) begin
      rsp_ready = (i == stalls) ? oh : ~oh;
      @(negedge clk);
      chk("rsp_valid", rsp_valid, oh);
      chk("rready_track", m_rready, (i == stalls));
      if (i == stalls) begin
        e = bq.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_resp", rsp_resp, e.resp);
        chk("rsp_last", rsp_last, e.last);
      end
      @(posedge clk); #1;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; rsp_ready = 2'b00; m_rid = '0;
  endtask

  initial begin
    bit w;
    rst_n = 1'b0; req_valid = 0; req_addr0 = 0; req_addr1 = 0; req_len0 = 0; req_len1 = 0;
    rsp_ready = 0; m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention: both held valid across four single-beat reads.
    req_addr0 = 64'h1000; req_addr1 = 64'h2000;
    for (int i = 0; i < 4; i++) begin
`ifdef HAWK_RD_ARB_STRICT_PRIO_EN
      w = 1'b0;
`else
      w = i[0];
`endif
      request(2'b11, w);
      ar_phase(w ? 64'h2000 : 64'h1000, 8'd0, {3'b0, w}, 0);
      if (i == 3) req_valid = 2'b00;
      beat(w, {16{32'hC0DE_0000 + i}}, 2'b00, 1'b1, {3'b0, w}, 0);
    end
    @(negedge clk);
    chk("contention_len_err", len_err, 0);
    @(posedge clk); #1;

    // Single read from requester 0.
    req_addr0 = 64'h8000_0040; req_len0 = 8'd0;
    request(2'b01, 1'b0);
    req_valid = 2'b00; req_addr0 = 64'hDEAD;
    ar_phase(64'h8000_0040, 8'd0, 4'd0, 0);
    beat(1'b0, {8{64'h0123_4567_89AB_CDEF}}, 2'b00, 1'b1, 4'd0, 0);

    // Back in IDLE: requester 1 is granted at once. Burst of 4 with backpressure.
    req_addr1 = 64'hC000_1000; req_len1 = 8'd3;
    request(2'b10, 1'b1);
    req_valid = 2'b00; req_addr1 = 64'h5555; req_len1 = 8'd9;
    ar_phase(64'hC000_1000, 8'd3, 4'd1, 5);
    beat(1'b1, {16{32'hA0A0_0001}}, 2'b00, 1'b0, 4'd1, 1);
    beat(1'b1, {16{32'hA0A0_0002}}, 2'b10, 1'b0, 4'd1, 0);
    beat(1'b1, {16{32'hA0A0_0003}}, 2'b11, 1'b0, 4'd1, 2);
    beat(1'b1, {16{32'hA0A0_0004}}, 2'b00, 1'b1, 4'd1, 1);
    @(negedge clk);
    chk("bp_len_err", len_err, 0);
    chk("bp_idle_arvalid", m_arvalid, 0);
    @(posedge clk); #1;

    // Early rlast on beat 2 of a len-3 burst.
    req_addr0 = 64'h4000; req_len0 = 8'd3;
    request(2'b01, 1'b0);
    req_valid = 2'b00;
    ar_phase(64'h4000, 8'd3, 4'd0, 0);
    beat(1'b0, {16{32'hE0000001}}, 2'b00, 1'b0, 4'd0, 0);
    beat(1'b0, {16{32'hE0000002}}, 2'b00, 1'b1, 4'd0, 0);
    @(negedge clk);
    chk("early_len_err", len_err, 1);
    @(posedge clk); #1;

    // Reset asserted mid-R; a sticky error must also clear.
    req_addr0 = 64'h6000; req_len0 = 8'd1;
    request(2'b01, 1'b0);
    req_valid = 2'b00;
    ar_phase(64'h6000, 8'd1, 4'd0, 0);
    m_rvalid = 1'b1; m_rdata = {16{32'h7777_7777}}; rsp_ready = 2'b01;
    @(negedge clk);
    chk("pre_reset_rsp_valid", rsp_valid, 2'b01);
    chk("pre_reset_len_err", len_err, 1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    m_rvalid = 1'b0; m_rdata = 0; rsp_ready = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fresh pointer favours requester 0; rid=1 on its burst flags an error.
    req_addr0 = 64'h9000; req_len0 = 8'd0; req_addr1 = 64'hA000; req_len1 = 8'd0;
    request(2'b11, 1'b0);
    req_valid = 2'b00;
    ar_phase(64'h9000, 8'd0, 4'd0, 0);
    beat(1'b0, {16{32'hBEEF_0001}}, 2'b00, 1'b1, 4'd1, 0);
    @(negedge clk);
    chk("wrong_rid_len_err", len_err, 1);
    chk("scoreboard_empty", bq.size() + gq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hawk_rd_arb.md
# hawk_rd_arb

Two-requester AXI4 read-channel arbiter for the HACD hawk engine. It shares the single hawk AXI read master between the page-read manager and the compression manager. The page-read manager issues ATT and TOL cacheline reads; the compression manager issues ZsPage metadata reads. The block serializes their AR requests, allows one outstanding read burst at a time, and steers R beats back to the owning requester.

## Interface
- ADDR_W, 64 (`HACD_AXI4_ADDR_WIDTH`), address width.
- DATA_W, 512 (`HACD_AXI4_DATA_WIDTH`), read data width (one 64B cacheline).
- ID_W, 4, AXI ID width.
- clk_i  in  1  block clock; everything is on one clock.
- rst_ni  in  1  reset, asynchronous and active-low.
- req_valid_i  in  2  request valid; bit 0 is the page-read manager, bit 1 is the compression manager.
- req_addr0_i, req_addr1_i  in  ADDR_W each  request byte address.
- req_len0_i, req_len1_i  in  8 each  AXI arlen (beats minus 1).
- req_ready_o  out  2  one-hot accept pulse.
- rsp_valid_o  out  2  one-hot read-beat valid.
- rsp_ready_i  in  2  per-requester beat ready.
- rsp_data_o  out  DATA_W  shared read data.
- rsp_resp_o  out  2  shared rresp.
- rsp_last_o  out  1  shared rlast.
- m_araddr_o  out  ADDR_W  AR address.
- m_arlen_o  out  8  AR length.
- m_arid_o  out  ID_W  AR ID.
- m_arvalid_o  out  1  AR valid.
- m_arready_i  in  1  AR ready.
- m_rvalid_i  in  1  R valid.
- m_rdata_i  in  DATA_W  R data.
- m_rresp_i  in  2  R response.
- m_rlast_i  in  1  R last.
- m_rid_i  in  ID_W  R ID.
- m_rready_o  out  1  R ready.
- len_err_o  out  1  sticky burst-length error.

## Operation
- FSM states are IDLE, AR and R. Reset state is IDLE.
- IDLE: if any req_valid_i bit is set, select the winner and pulse req_ready_o[winner] combinationally in the same cycle.
  - At that edge, latch addr, len and owner.
  - Set m_arid_o = owner, zero-extended.
  - Load the beat counter with len.
  - Move to AR.
- AR: hold m_arvalid_o=1 with stable m_araddr_o, m_arlen_o and m_arid_o until m_arready_i. On the handshake edge, move to R.
- R: data path is pure combinational pass-through.
  - rsp_valid_o[owner] = m_rvalid_i.
  - m_rready_o = rsp_ready_i[owner].
  - rsp_data_o, rsp_resp_o and rsp_last_o are driven from the corresponding m_r* inputs.
  - On each beat handshake the beat counter decrements.
  - A beat handshake with m_rlast_i=1 returns the FSM to IDLE.
- Round-robin arbitration:
  - A priority pointer is reset to 0, which favours requester 0.
  - On a grant, the pointer moves to the other requester.
  - With a single requester pending, that requester wins regardless of the pointer.
- Length check: set len_err_o and hold it until reset on either condition:
  - m_rlast_i=1 with counter≠0 (rlast early).
  - Counter=0 on a non-last beat (rlast late). The counter does not wrap below 0.
- Owner check: if m_rid_i≠latched ID on a beat, set len_err_o as well. Data is still routed to the latched owner.
- rresp: SLVERR and DECERR are passed through unmodified. There is no retry.
- Non-owner: its rsp_valid_o and req_ready_o bits stay 0 while the FSM is not IDLE.
- Outside R: m_rready_o=0 and rsp_valid_o=0.

## Timing
- Reset values:
  - All outputs are 0 (m_araddr_o, m_arlen_o and m_arid_o included).
  - FSM is IDLE, pointer is 0, beat counter is 0, len_err_o is 0.
- Reset mid-transaction aborts immediately to IDLE. There is no drain, and the outstanding burst is the system's concern.
- Latency:
  - req_valid_i at cycle N gives req_ready_o at N when IDLE.
  - m_arvalid_o rises at N+1.
  - R beats have zero-cycle pass-through.
  - After the last beat handshake at cycle M, IDLE is at M+1 and the next grant can occur at M+1.
- Minimum cost is 3 cycles per single-beat read, with m_arready_i and the R beat arriving on the first possible cycles.
- Requesters hold valid, addr and len stable until req_ready_o. A request may be withdrawn only in cycles where it has not been granted.
- m_arvalid_o never deasserts before m_arready_i, per AXI.

## Configuration
- HAWK_RD_ARB_STRICT_PRIO_EN:
  - Defined: requester 0 (page-read manager) always wins simultaneous requests. The priority pointer is not implemented.
  - Undefined (default): round-robin as above.

## Test plan
- Single read: req_valid_i=01, addr 0x8000_0040, len 0. Required response:
  - req_ready_o=01 in the same cycle.
  - Next cycle m_araddr_o=0x8000_0040, m_arid_o=0.
  - One beat with rlast routed to rsp_valid_o=01.
  - Back in IDLE after 3 cycles.
- Contention: both requesters valid continuously, 4 single-beat reads. Required grant order is 0,1,0,1. With HAWK_RD_ARB_STRICT_PRIO_EN defined, the order is 0,0,0,0.
- Backpressure: len 3 burst from requester 1, m_arready_i low for 5 cycles, rsp_ready_i[1] toggling. Required response:
  - AR fields stay stable until the handshake.
  - Exactly 4 beats are delivered.
  - m_rready_o tracks rsp_ready_i[1].
  - len_err_o stays 0.
- Early rlast: len 3 with rlast on beat 2. Required response: len_err_o=1 sticky, FSM returns to IDLE.
- Wrong rid: rid=1 on a requester-0 burst. Required response: data goes to requester 0 and len_err_o=1.
- Async reset asserted while in R. Required response: all outputs are 0 immediately and the FSM is in IDLE. After release, a new request is granted to requester 0.
